// File: rtl/batalha_naval_board_param.sv
// Naval-battle board engine: ship layout load, cursor-driven attack shots,
// hit/miss/repeat classification with hit counting, game-over detection and a
// column-scanned LED matrix driver with an RGB result indicator.
module batalha_naval_board_param #(
    parameter int ROWS     = 7,
    parameter int COLS     = 5,
    parameter int SCAN_DIV = 50000,
    parameter int SHOW_CYC = 25000000
) (
    input  logic                             clk,
    input  logic                             clr_n,
    input  logic [1:0]                       mode,
    input  logic                             btn_confirm,
    input  logic                             btn_next,
    input  logic [ROWS*COLS-1:0]             layout_in,
    output logic [COLS-1:0]                  m_col,
    output logic [ROWS-1:0]                  m_line,
    output logic [$clog2(ROWS)-1:0]          cursor_row,
    output logic [$clog2(COLS)-1:0]          cursor_col,
    output logic [1:0]                       rgb_output,
    output logic [$clog2(ROWS*COLS+1)-1:0]   hits,
    output logic                             game_over
);

    localparam int N  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int IW = $clog2(N);
    localparam int HW = $clog2(N + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
    // Second prescaler stage: counts scan steps, its MSB blinks the cursor.
    localparam int BW = 8;

    typedef enum logic [1:0] {IDLE, ARMED, SHOW, OVER} state_t;

    function automatic logic [HW-1:0] popcount(input logic [N-1:0] v);
        logic [HW-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) s = s + HW'(1);
        end
        return s;
    endfunction

    function automatic logic [CW-1:0] col_step(input logic [CW-1:0] c);
        return (c == CW'(COLS - 1)) ? '0 : c + CW'(1);
    endfunction

    state_t          state_q, state_n;
    logic [N-1:0]    ship_q, ship_n;
    logic [N-1:0]    atk_q, atk_n;
    logic [HW-1:0]   hits_q, hits_n;
    logic [HW-1:0]   cnt_q, cnt_n;
    logic [RW-1:0]   row_q, row_n;
    logic [CW-1:0]   col_q, col_n;
    logic [1:0]      rgb_q, rgb_n;
    logic [SW-1:0]   show_q, show_n;
    logic            rej_q, rej_n;

    logic [IW-1:0]   cur_idx;
    logic [HW-1:0]   lay_cnt;
    logic            show_last;

    assign cur_idx   = IW'(row_q) * IW'(COLS) + IW'(col_q);
    assign lay_cnt   = popcount(layout_in);
    assign show_last = (show_q == SW'(SHOW_CYC - 1));

    // Game state register and all game bookkeeping registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            ship_q  <= '0;
            atk_q   <= '0;
            hits_q  <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rgb_q   <= 2'b00;
            show_q  <= '0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            ship_q  <= ship_n;
            atk_q   <= atk_n;
            hits_q  <= hits_n;
            cnt_q   <= cnt_n;
            row_q   <= row_n;
            col_q   <= col_n;
            rgb_q   <= rgb_n;
            show_q  <= show_n;
            rej_q   <= rej_n;
        end
    end

    // Next-state logic: load, cursor moves, shot classification, result hold.
    always_comb begin
        state_n = state_q;
        ship_n  = ship_q;
        atk_n   = atk_q;
        hits_n  = hits_q;
        cnt_n   = cnt_q;
        row_n   = row_q;
        col_n   = col_q;
        rgb_n   = rgb_q;
        show_n  = show_q;
        rej_n   = rej_q;
        if (mode == 2'b00) begin
            // Clear the game but keep the loaded layout for a replay.
            state_n = IDLE;
            atk_n   = '0;
            hits_n  = '0;
            row_n   = '0;
            col_n   = '0;
            rgb_n   = 2'b00;
            show_n  = '0;
            rej_n   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (btn_confirm && mode == 2'b01) begin
                        show_n = '0;
                        if (lay_cnt == '0) begin
                            // An empty board can never be won: flag it and stay.
                            rgb_n = 2'b11;
                            rej_n = 1'b1;
                        end else begin
                            ship_n  = layout_in;
                            cnt_n   = lay_cnt;
                            atk_n   = '0;
                            hits_n  = '0;
                            row_n   = '0;
                            col_n   = '0;
                            rgb_n   = 2'b00;
                            rej_n   = 1'b0;
                            state_n = ARMED;
                        end
                    end else if (rej_q) begin
                        if (show_last) begin
                            rgb_n  = 2'b00;
                            rej_n  = 1'b0;
                            show_n = '0;
                        end else begin
                            show_n = show_q + SW'(1);
                        end
                    end
                end
                ARMED: begin
                    if (mode == 2'b10) begin
                        if (btn_confirm) begin
                            if (atk_q[cur_idx]) begin
                                rgb_n = 2'b11;
                            end else begin
                                atk_n[cur_idx] = 1'b1;
                                if (ship_q[cur_idx]) begin
                                    rgb_n = 2'b10;
                                    if (hits_q < cnt_q) hits_n = hits_q + HW'(1);
                                end else begin
                                    rgb_n = 2'b01;
                                end
                            end
                            show_n  = '0;
                            state_n = SHOW;
                        end else if (btn_next) begin
                            col_n = col_step(col_q);
                            if (col_q == CW'(COLS - 1)) begin
                                row_n = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                            end
                        end
                    end
                end
                SHOW: begin
                    if (show_last) begin
                        show_n  = '0;
                        rgb_n   = 2'b00;
                        state_n = (hits_q == cnt_q) ? OVER : ARMED;
                    end else begin
                        show_n = show_q + SW'(1);
                    end
                end
                OVER: begin
                    if (btn_confirm) begin
                        atk_n   = '0;
                        hits_n  = '0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    logic [PW-1:0]   presc_q;
    logic [CW-1:0]   scol_q, scol_n;
    logic [BW-1:0]   blink_q;
    logic            scan_wrap;
    logic [N-1:0]    pix;
    logic [N-1:0]    cur_mask;
    logic [ROWS-1:0] line_n;
    logic [COLS-1:0] mcol_n;

    assign scan_wrap = (presc_q == PW'(SCAN_DIV - 1));
    assign scol_n    = scan_wrap ? col_step(scol_q) : scol_q;
    assign cur_mask  = N'(1) << cur_idx;

    // Pixel source selection for the board view currently shown.
    always_comb begin
        pix = '0;
        if (state_q != IDLE && mode == 2'b11) begin
            pix = ship_q;
        end else begin
            unique case (state_q)
                ARMED, SHOW: pix = atk_q | (cur_mask & {N{blink_q[BW-1]}});
                OVER:        pix = ship_q & atk_q;
                default:     pix = '0;
            endcase
        end
    end

    // Row drive and column enable for the column about to be displayed.
    always_comb begin
        line_n = '1;
        mcol_n = '0;
        for (int c = 0; c < COLS; c++) begin
            if (CW'(c) == scol_n) begin
                mcol_n[c] = 1'b1;
                for (int r = 0; r < ROWS; r++) begin
                    line_n[r] = ~pix[r*COLS + c];
                end
            end
        end
    end

    // Scan prescaler, blink stage and registered matrix outputs, all on one edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            presc_q <= '0;
            scol_q  <= '0;
            blink_q <= '0;
            m_col   <= {{(COLS-1){1'b0}}, 1'b1};
            m_line  <= '1;
        end else begin
            presc_q <= scan_wrap ? '0 : presc_q + PW'(1);
            if (scan_wrap) blink_q <= blink_q + BW'(1);
            scol_q  <= scol_n;
            m_col   <= mcol_n;
            m_line  <= line_n;
        end
    end

    assign cursor_row = row_q;
    assign cursor_col = col_q;
    assign rgb_output = rgb_q;
    assign hits       = hits_q;
    assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_batalha_naval_board_param.sv
// Bench for the naval-battle board engine: directed vector table, hand-written
// corner sequences and randomized games against a set-based board model.
module tb_batalha_naval_board_param;

    localparam int ROWS = 7;
    localparam int COLS = 5;
    localparam int SCAN_DIV = 2;
    localparam int SHOW_CYC = 4;
    localparam int N = ROWS * COLS;

    logic            clk = 1'b0;
    logic            clr_n = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic            btn_confirm = 1'b0;
    logic            btn_next = 1'b0;
    logic [N-1:0]    layout_in = '0;
    logic [COLS-1:0] m_col;
    logic [ROWS-1:0] m_line;
    logic [2:0]      cursor_row;
    logic [2:0]      cursor_col;
    logic [1:0]      rgb_output;
    logic [5:0]      hits;
    logic            game_over;

    batalha_naval_board_param #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .SHOW_CYC(SHOW_CYC)
    ) dut (
        .clk(clk), .clr_n(clr_n), .mode(mode), .btn_confirm(btn_confirm),
        .btn_next(btn_next), .layout_in(layout_in), .m_col(m_col), .m_line(m_line),
        .cursor_row(cursor_row), .cursor_col(cursor_col), .rgb_output(rgb_output),
        .hits(hits), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Board model: ship and shot sets, linear cursor position, ship count.
    logic [N-1:0] mship = '0;
    logic [N-1:0] matk = '0;
    int mpos = 0;
    int mcnt = 0;

    typedef struct {
        logic [1:0]   md;
        bit           cf;
        bit           nx;
        logic [N-1:0] lay;
        int           wt;
        int           rgb;
        int           hit;
        int           pos;
        int           go;
    } vec_t;

    vec_t tbl[9];

    function automatic int mhits();
        return $countones(mship & matk);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] md, input bit cf, input bit nx, input logic [N-1:0] lay);
        mode = md;
        btn_confirm = cf;
        btn_next = nx;
        layout_in = lay;
        cyc();
        btn_confirm = 1'b0;
        btn_next = 1'b0;
    endtask

    task automatic check_state(input string name, input int rgb, input int h, input int pos, input int go);
        chk({name, ".rgb"}, int'(rgb_output), rgb);
        chk({name, ".hits"}, int'(hits), h);
        chk({name, ".row"}, int'(cursor_row), pos / COLS);
        chk({name, ".col"}, int'(cursor_col), pos % COLS);
        chk({name, ".game_over"}, int'(game_over), go);
    endtask

    task automatic wait_show();
        repeat (SHOW_CYC) cyc();
    endtask

    // view: 0 blank, 1 attack (cursor cell masked, it blinks), 2 ship&attack, 3 ship
    task automatic check_disp(input int view);
        for (int k = 0; k < COLS * SCAN_DIV; k++) begin
            int c;
            logic [ROWS-1:0] exp_line;
            logic [ROWS-1:0] mask;
            cyc();
            c = -1;
            for (int j = 0; j < COLS; j++) if (m_col == COLS'(1 << j)) c = j;
            chk("m_col_onehot", int'(c >= 0), 1);
            if (c >= 0) begin
                for (int r = 0; r < ROWS; r++) begin
                    int idx;
                    logic p;
                    idx = r * COLS + c;
                    case (view)
                        1: p = matk[idx];
                        2: p = mship[idx] & matk[idx];
                        3: p = mship[idx];
                        default: p = 1'b0;
                    endcase
                    exp_line[r] = ~p;
                    mask[r] = !(view == 1 && idx == mpos);
                end
                chk($sformatf("m_line_v%0d_c%0d", view, c), int'(m_line & mask), int'(exp_line & mask));
            end
        end
    endtask

    task automatic move_to(input int target);
        int steps;
        steps = (target - mpos + N) % N;
        repeat (steps) begin
            press(2'b10, 1'b0, 1'b1, '0);
            mpos = (mpos + 1) % N;
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b00, 0, 0, '0,          0, 0, 0, 0, 0};
        tbl[1] = '{2'b01, 1, 0, N'(35'h41),  0, 0, 0, 0, 0};
        tbl[2] = '{2'b10, 1, 0, '0,          0, 2, 1, 0, 0};
        tbl[3] = '{2'b10, 0, 0, '0,          1, 2, 1, 0, 0};
        tbl[4] = '{2'b10, 0, 1, '0,          0, 2, 1, 0, 0};
        tbl[5] = '{2'b10, 0, 0, '0,          0, 0, 1, 0, 0};
        tbl[6] = '{2'b10, 0, 1, '0,          0, 0, 1, 1, 0};
        tbl[7] = '{2'b10, 1, 0, '0,          0, 1, 1, 1, 0};
        tbl[8] = '{2'b10, 0, 0, '0,          3, 0, 1, 1, 0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst.m_col", int'(m_col), 1);
        chk("rst.m_line", int'(m_line), 7'h7F);
        check_state("rst", 0, 0, 0, 0);

        // Column scan: one step every SCAN_DIV clocks after reset release
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk($sformatf("scan%0d", k), int'(m_col), 1 << ((k / SCAN_DIV) % COLS));
            chk($sformatf("scan_line%0d", k), int'(m_line), 7'h7F);
        end

        // Directed table: load, hit, show hold, ignored next, miss
        for (int i = 0; i < 9; i++) begin
            press(tbl[i].md, tbl[i].cf, tbl[i].nx, tbl[i].lay);
            repeat (tbl[i].wt) cyc();
            check_state($sformatf("vec%0d", i), tbl[i].rgb, tbl[i].hit, tbl[i].pos, tbl[i].go);
        end
        mship = N'(35'h41);
        matk = N'(35'h03);
        mpos = 1;
        mcnt = 2;
        check_disp(1);

        // Reveal mode: buttons ignored, ship layout shown
        press(2'b11, 1'b0, 1'b1, '0);
        check_state("reveal", 0, 1, 1, 0);
        check_disp(3);

        // Cursor wrap, then confirm+next together on an already-shot cell
        mode = 2'b10;
        move_to(34);
        check_state("wrap_end", 0, 1, 34, 0);
        press(2'b10, 1'b0, 1'b1, '0);
        mpos = 0;
        check_state("wrap_zero", 0, 1, 0, 0);
        press(2'b10, 1'b1, 1'b1, '0);
        check_state("repeat", 3, 1, 0, 0);
        wait_show();
        check_state("repeat_done", 0, 1, 0, 0);

        // Win on (1,1), then back to IDLE
        move_to(6);
        press(2'b10, 1'b1, 1'b0, '0);
        matk[6] = 1'b1;
        check_state("win_shot", 2, 2, 6, 0);
        wait_show();
        check_state("win_over", 0, 2, 6, 1);
        check_disp(2);
        press(2'b10, 1'b1, 1'b0, '0);
        matk = '0;
        check_state("over_exit", 0, 0, 6, 0);
        mode = 2'b11;
        check_disp(0);

        // Empty layout load is rejected and the engine stays in IDLE
        press(2'b01, 1'b1, 1'b0, '0);
        check_state("empty_load", 3, 0, 6, 0);
        press(2'b10, 1'b0, 1'b1, '0);
        check_state("empty_hold", 3, 0, 6, 0);
        repeat (SHOW_CYC - 1) cyc();
        check_state("empty_done", 0, 0, 6, 0);
        check_disp(0);

        // Asynchronous reset in the middle of a result display
        press(2'b01, 1'b1, 1'b0, N'(35'h41));
        mpos = 0;
        check_state("reload", 0, 0, 0, 0);
        press(2'b10, 1'b1, 1'b0, '0);
        check_state("pre_rst_shot", 2, 1, 0, 0);
        cyc();
        #2;
        clr_n = 1'b0;
        #1;
        chk("arst.m_line", int'(m_line), 7'h7F);
        chk("arst.m_col", int'(m_col), 1);
        check_state("arst", 0, 0, 0, 0);
        @(negedge clk);
        clr_n = 1'b1;
        mship = '0;
        matk = '0;
        mpos = 0;
        press(2'b10, 1'b1, 1'b0, '0);
        check_state("arst_idle", 0, 0, 0, 0);

        // Randomized games against the board model
        for (int g = 0; g < 6; g++) begin
            logic [N-1:0] lay;
            int ship_idx[$];
            lay = '0;
            repeat ($urandom_range(1, 3)) lay[$urandom_range(0, N - 1)] = 1'b1;
            press(2'b01, 1'b1, 1'b0, lay);
            mship = lay;
            matk = '0;
            mpos = 0;
            mcnt = $countones(lay);
            check_state($sformatf("g%0d.load", g), 0, 0, 0, 0);
            ship_idx = {};
            for (int i = 0; i < N; i++) if (lay[i]) ship_idx.push_back(i);
            for (int a = 0; a < 30; a++) begin
                int t;
                int exp_rgb;
                bit won;
                if ($urandom_range(0, 1) == 1)
                    t = ship_idx[$urandom_range(0, ship_idx.size() - 1)];
                else
                    t = $urandom_range(0, N - 1);
                move_to(t);
                exp_rgb = matk[t] ? 3 : (mship[t] ? 2 : 1);
                matk[t] = 1'b1;
                press(2'b10, 1'b1, 1'b0, '0);
                check_state($sformatf("g%0d.a%0d.shot", g, a), exp_rgb, mhits(), mpos, 0);
                wait_show();
                won = (mhits() == mcnt);
                check_state($sformatf("g%0d.a%0d.after", g, a), 0, mhits(), mpos, int'(won));
                if (won || a % 8 == 0) check_disp(won ? 2 : 1);
                if (won) begin
                    press(2'b10, 1'b1, 1'b0, '0);
                    matk = '0;
                    check_state($sformatf("g%0d.exit", g), 0, 0, mpos, 0);
                    break;
                end
            end
            press(2'b00, 1'b0, 1'b0, '0);
            matk = '0;
            mpos = 0;
            check_state($sformatf("g%0d.clear", g), 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
